// File: rtl/mhsa_icb_pkg.sv
// Shared types and helpers for the MHSA ICB bridge: FSM states, CSR offsets, lane merge.
package mhsa_icb_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_CAP   = 3'd2,
    WR       = 3'd3,
    RSP      = 3'd4
  } bridge_state_e;

  localparam int CSR_START    = 32'h0;
  localparam int CSR_DONE     = 32'h4;
  localparam int CSR_IN_BASE  = 32'h8;
  localparam int CSR_OUT_BASE = 32'hC;

  // Replace the enabled bytes of one 32-bit lane; the other lane passes through untouched.
  function automatic logic [63:0] merge_lane(input logic [63:0] old64,
                                             input logic [31:0] wdata32,
                                             input logic [3:0]  wmask4,
                                             input logic        lane);
    logic [63:0] merged;
    merged = old64;
    for (int b = 0; b < 4; b++) begin
      if (wmask4[b]) begin
        merged[(lane ? 32 : 0) + b*8 +: 8] = wdata32[b*8 +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/mhsa_csr_bank.sv
// CSR bank: START/busy, sticky DONE (W1C), INPUT_BASE and OUTPUT_BASE with byte-masked writes.
module mhsa_csr_bank
  import mhsa_icb_pkg::*;
#(
  parameter int OW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [OW-1:0] offset,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wmask,
  input  logic          done_in,
  output logic [31:0]   rdata,
  output logic          hit,
  output logic          start,
  output logic          busy,
  output logic [31:0]   input_base,
  output logic [31:0]   output_base
);

  logic sel_start, sel_done, sel_in, sel_out;
  logic done_sticky;
  logic go;

  function automatic logic [31:0] apply_mask(input logic [31:0] old,
                                             input logic [31:0] wd,
                                             input logic [3:0]  wm);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (wm[b]) res[b*8 +: 8] = wd[b*8 +: 8];
    end
    return res;
  endfunction

  always_comb begin
    sel_start = (offset == OW'(CSR_START));
    sel_done  = (offset == OW'(CSR_DONE));
    sel_in    = (offset == OW'(CSR_IN_BASE));
    sel_out   = (offset == OW'(CSR_OUT_BASE));
    hit       = sel_start | sel_done | sel_in | sel_out;
    rdata     = 32'h0;
    if (sel_start)     rdata = {31'b0, busy};
    else if (sel_done) rdata = {31'b0, done_sticky};
    else if (sel_in)   rdata = input_base;
    else if (sel_out)  rdata = output_base;
  end

  // A START request while the accelerator is still busy is silently dropped.
  assign go = wr_en & sel_start & wmask[0] & wdata[0] & ~busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      start       <= 1'b0;
      busy        <= 1'b0;
      done_sticky <= 1'b0;
      input_base  <= 32'h0;
      output_base <= 32'h0;
    end else begin
      start <= go;
      if (go)           busy <= 1'b1;
      else if (done_in) busy <= 1'b0;
      // done_in beats a simultaneous W1C so a completion is never lost
      if (done_in)                                         done_sticky <= 1'b1;
      else if (wr_en & sel_done & wmask[0] & wdata[0])     done_sticky <= 1'b0;
      if (wr_en & sel_in)  input_base  <= apply_mask(input_base, wdata, wmask);
      if (wr_en & sel_out) output_base <= apply_mask(output_base, wdata, wmask);
    end
  end

endmodule

// File: rtl/icb_usram_bridge.sv
// ICB slave bridge to CSR bank and 64-bit usram (RMW for 32-bit masked writes), one outstanding txn.
// Optional ICB_BRIDGE_ERR_EN: error responses for out-of-range/busy usram access and undefined CSRs.
module icb_usram_bridge
  import mhsa_icb_pkg::*;
#(
  parameter int USRAM_DEPTH = 4096,
  parameter int REGION_BIT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        icb_cmd_valid,
  output logic        icb_cmd_ready,
  input  logic        icb_cmd_read,
  input  logic [31:0] icb_cmd_addr,
  input  logic [31:0] icb_cmd_wdata,
  input  logic [3:0]  icb_cmd_wmask,
  output logic        icb_rsp_valid,
  input  logic        icb_rsp_ready,
  output logic [31:0] icb_rsp_rdata,
  output logic        icb_rsp_err,
  output logic        start,
  input  logic        done_in,
  output logic [31:0] input_base,
  output logic [31:0] output_base,
  output logic [31:0] usram_addr,
  output logic [63:0] usram_wdata,
  output logic        usram_write_en,
  input  logic [63:0] usram_rdata
);

  bridge_state_e state;
  logic          lane_q, write_q;
  logic [31:0]   wdata_q, rdata_q, word_q;
  logic [3:0]    wmask_q;
  logic [63:0]   old_q;

  logic          accept, csr_sel, csr_hit, busy;
  logic [31:0]   word_full, csr_rdata;
  logic          unused_ok;

  assign accept    = (state == IDLE) & icb_cmd_valid;
  assign csr_sel   = icb_cmd_addr[REGION_BIT];
  assign word_full = 32'(icb_cmd_addr[REGION_BIT-1:3]);

  mhsa_csr_bank #(.OW(REGION_BIT)) u_csr (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (accept & csr_sel & ~icb_cmd_read),
    .offset      ({icb_cmd_addr[REGION_BIT-1:2], 2'b00}),
    .wdata       (icb_cmd_wdata),
    .wmask       (icb_cmd_wmask),
    .done_in     (done_in),
    .rdata       (csr_rdata),
    .hit         (csr_hit),
    .start       (start),
    .busy        (busy),
    .input_base  (input_base),
    .output_base (output_base)
  );

`ifdef ICB_BRIDGE_ERR_EN
  logic err_q;
  logic usram_err;
  // The accelerator owns usram while busy, so host accesses are refused then.
  assign usram_err   = (word_full >= 32'(USRAM_DEPTH)) | busy;
  assign icb_rsp_err = err_q;
  assign unused_ok   = ^{icb_cmd_addr[31:REGION_BIT+1], icb_cmd_addr[1:0]};
`else
  assign icb_rsp_err = 1'b0;
  assign unused_ok   = ^{icb_cmd_addr[31:REGION_BIT+1], icb_cmd_addr[1:0], csr_hit, busy};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lane_q  <= 1'b0;
      write_q <= 1'b0;
      wdata_q <= 32'h0;
      wmask_q <= 4'h0;
      rdata_q <= 32'h0;
      word_q  <= 32'h0;
      old_q   <= 64'h0;
`ifdef ICB_BRIDGE_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lane_q  <= icb_cmd_addr[2];
            write_q <= ~icb_cmd_read;
            wdata_q <= icb_cmd_wdata;
            wmask_q <= icb_cmd_wmask;
            rdata_q <= 32'h0;
            word_q  <= word_full % 32'(USRAM_DEPTH);
`ifdef ICB_BRIDGE_ERR_EN
            err_q   <= 1'b0;
`endif
            if (csr_sel) begin
              // CSR side effects land on this edge; the response follows immediately.
              if (icb_cmd_read) rdata_q <= csr_rdata;
`ifdef ICB_BRIDGE_ERR_EN
              err_q <= ~csr_hit;
`endif
              state <= RSP;
`ifdef ICB_BRIDGE_ERR_EN
            end else if (usram_err) begin
              err_q <= 1'b1;
              state <= RSP;
`endif
            end else begin
              state <= RD_ISSUE;
            end
          end
        end
        RD_ISSUE: state <= RD_CAP;
        RD_CAP: begin
          old_q <= usram_rdata;
          if (write_q) begin
            state <= WR;
          end else begin
            rdata_q <= lane_q ? usram_rdata[63:32] : usram_rdata[31:0];
            state   <= RSP;
          end
        end
        WR:  state <= RSP;
        RSP: if (icb_rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign icb_cmd_ready  = (state == IDLE);
  assign icb_rsp_valid  = (state == RSP) & ~rst;
  assign icb_rsp_rdata  = rdata_q;
  assign usram_addr     = (state inside {RD_ISSUE, RD_CAP, WR}) ? word_q : 32'h0;
  assign usram_write_en = (state == WR) & ~rst;
  assign usram_wdata    = (state == WR) ? merge_lane(old_q, wdata_q, wmask_q, lane_q) : 64'h0;

endmodule

// File: tb/tb_icb_usram_bridge.sv
// Scoreboard bench for icb_usram_bridge with a registered-read usram model.
module tb_icb_usram_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        icb_cmd_valid = 1'b0;
  logic        icb_cmd_ready;
  logic        icb_cmd_read = 1'b0;
  logic [31:0] icb_cmd_addr = 32'h0;
  logic [31:0] icb_cmd_wdata = 32'h0;
  logic [3:0]  icb_cmd_wmask = 4'h0;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready = 1'b1;
  logic [31:0] icb_rsp_rdata;
  logic        icb_rsp_err;
  logic        start;
  logic        done_in = 1'b0;
  logic [31:0] input_base, output_base, usram_addr;
  logic [63:0] usram_wdata, usram_rdata;
  logic        usram_write_en;

  icb_usram_bridge dut (
    .clk(clk), .rst(rst),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
    .icb_cmd_read(icb_cmd_read), .icb_cmd_addr(icb_cmd_addr),
    .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
    .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err),
    .start(start), .done_in(done_in),
    .input_base(input_base), .output_base(output_base),
    .usram_addr(usram_addr), .usram_wdata(usram_wdata),
    .usram_write_en(usram_write_en), .usram_rdata(usram_rdata)
  );

  always #5 clk = ~clk;

  logic [63:0] mem [0:4095];
  always @(posedge clk) begin
    if (usram_write_en) mem[usram_addr[11:0]] <= usram_wdata;
    usram_rdata <= mem[usram_addr[11:0]];
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_rsp = 0;
  int hs_cyc = 0;
  int we_cnt = 0;
  int we_cyc = 0;
  int start_cnt = 0;
  int last_acc = 0;
  logic [32:0] exp_q [$];

`ifdef ICB_BRIDGE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on every completed response handshake.
  always @(negedge clk) begin
    if (usram_write_en) begin
      we_cnt++;
      we_cyc = cyc + 1;
    end
    if (start) start_cnt++;
    if (icb_rsp_valid && icb_rsp_ready) begin
      logic [32:0] e;
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 64'(icb_rsp_rdata), 64'hX);
      end else begin
        e = exp_q.pop_front();
        check("rsp_rdata", 64'(icb_rsp_rdata), 64'(e[31:0]));
        check("rsp_err", 64'(icb_rsp_err), 64'(e[32]));
      end
      n_rsp++;
      hs_cyc = cyc + 1;
    end
  end

  task automatic issue(input logic rd, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] wm, input logic [31:0] exp_rd, input logic exp_err);
    int k;
    exp_q.push_back({exp_err, exp_rd});
    @(posedge clk); #1;
    icb_cmd_valid = 1'b1; icb_cmd_read = rd; icb_cmd_addr = addr;
    icb_cmd_wdata = wd; icb_cmd_wmask = wm;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (icb_cmd_ready) break;
    end
    if (k == 20) check("accept_timeout", 64'(k), 64'(0));
    @(posedge clk); #1;
    last_acc = cyc;
    icb_cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int base, input int lat);
    int k;
    for (k = 0; k < 50; k++) begin
      if (n_rsp > base) break;
      @(posedge clk); #1;
    end
    if (k == 50) check("rsp_timeout", 64'(k), 64'(0));
    else if (lat >= 0) check("rsp_latency", 64'(hs_cyc - last_acc), 64'(lat));
  endtask

  task automatic run(input logic rd, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] wm, input logic [31:0] exp_rd, input logic exp_err,
                     input int lat);
    int base;
    base = n_rsp;
    issue(rd, addr, wd, wm, exp_rd, exp_err);
    wait_rsp(base, lat);
  endtask

  initial begin
    int we0, st0, base;
    for (int i = 0; i < 4096; i++) mem[i] = 64'h0;
    mem[0] = 64'hCAFE_F00D_1234_5678;
    mem[2] = 64'h0123_4567_89AB_CDEF;
    mem[5] = 64'h1111_2222_3333_4444;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", 64'(icb_cmd_ready), 64'(1));
    check("rst_rsp_valid", 64'(icb_rsp_valid), 64'(0));
    check("rst_start", 64'(start), 64'(0));
    check("rst_write_en", 64'(usram_write_en), 64'(0));
    check("rst_bases", {input_base, output_base}, 64'h0);
    check("rst_usram_addr", 64'(usram_addr), 64'(0));

    run(1'b1, 32'h0001_0008, 32'h0, 4'h0, 32'h0, 1'b0, 1);

    we0 = we_cnt;
    run(1'b0, 32'h0000_0014, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 4);
    check("we_pulses_w2", 64'(we_cnt - we0), 64'(1));
    check("we_time_w2", 64'(we_cyc - last_acc), 64'(3));
    check("mem_w2", mem[2], 64'hDEAD_BEEF_89AB_CDEF);
    run(1'b1, 32'h0000_0014, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 3);
    run(1'b1, 32'h0000_0010, 32'h0, 4'h0, 32'h89AB_CDEF, 1'b0, 3);

    run(1'b0, 32'h0000_0028, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0, 4);
    check("mem_w5_mask", mem[5], 64'h1111_2222_33BB_44DD);
    we0 = we_cnt;
    run(1'b0, 32'h0000_002C, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, 4);
    check("we_pulses_mask0", 64'(we_cnt - we0), 64'(1));
    check("mem_w5_mask0", mem[5], 64'h1111_2222_33BB_44DD);

    run(1'b0, 32'h0001_0008, 32'h1234_5678, 4'b1100, 32'h0, 1'b0, 1);
    check("input_base", 64'(input_base), 64'h1234_0000);
    run(1'b1, 32'h0001_0008, 32'h0, 4'h0, 32'h1234_0000, 1'b0, 1);
    run(1'b0, 32'h0001_000C, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0, 1);
    check("output_base", 64'(output_base), 64'hA5A5_A5A5);
    run(1'b1, 32'h0001_0010, 32'h0, 4'h0, 32'h0, ERR_EN, 1);

    st0 = start_cnt;
    run(1'b0, 32'h0001_0000, 32'h1, 4'h1, 32'h0, 1'b0, 1);
    repeat (3) @(posedge clk);
    check("start_pulses", 64'(start_cnt - st0), 64'(1));
    run(1'b1, 32'h0001_0000, 32'h0, 4'h0, 32'h1, 1'b0, 1);
    st0 = start_cnt;
    run(1'b0, 32'h0001_0000, 32'h1, 4'h1, 32'h0, 1'b0, 1);
    repeat (3) @(posedge clk);
    check("start_while_busy", 64'(start_cnt - st0), 64'(0));
`ifdef ICB_BRIDGE_ERR_EN
    we0 = we_cnt;
    run(1'b0, 32'h0000_0028, 32'h0, 4'hF, 32'h0, 1'b1, 1);
    check("busy_no_write", 64'(we_cnt - we0), 64'(0));
    check("busy_mem_w5", mem[5], 64'h1111_2222_33BB_44DD);
`endif
    @(posedge clk); #1 done_in = 1'b1;
    @(posedge clk); #1 done_in = 1'b0;
    run(1'b1, 32'h0001_0004, 32'h0, 4'h0, 32'h1, 1'b0, 1);
    run(1'b1, 32'h0001_0000, 32'h0, 4'h0, 32'h0, 1'b0, 1);
    run(1'b0, 32'h0001_0004, 32'h1, 4'h1, 32'h0, 1'b0, 1);
    run(1'b1, 32'h0001_0004, 32'h0, 4'h0, 32'h0, 1'b0, 1);

    icb_rsp_ready = 1'b0;
    base = n_rsp;
    issue(1'b1, 32'h0000_0014, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (icb_rsp_valid) break;
    end
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", 64'(icb_rsp_valid), 64'(1));
      check("stall_rdata", 64'(icb_rsp_rdata), 64'hDEAD_BEEF);
      check("stall_cmd_ready", 64'(icb_cmd_ready), 64'(0));
      @(negedge clk);
    end
    @(posedge clk); #1 icb_rsp_ready = 1'b1;
    wait_rsp(base, -1);
    @(negedge clk);
    check("post_stall_idle", 64'(icb_cmd_ready), 64'(1));

    if (ERR_EN) run(1'b1, 32'h0000_8000, 32'h0, 4'h0, 32'h0, 1'b1, 1);
    else        run(1'b1, 32'h0000_8000, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 3);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
